lpddr2_port_arbiter: RTL and testbench
======================================

// Module: lpddr2_port_arbiter
// PURPOSE
//  Two-port round-robin arbiter and sequencer in front of the LPDDR2 Avalon-MM local port.
//  Port 0 is the CPU instruction fetch; port 1 is the CPU data/load-store port.
//  Each port uses a single-word req/done handshake. The block drives avl_* commands
//  and returns read data or write completion to the port that won the grant.
// PARAMETERS
//  ADDR_W   27    Avalon word-address width.
//  DATA_W   32    Data width.
//  TIMEOUT  1023  Max cycles in RDWAIT before a read is aborted with an error.
// PORTS
//  iCLK               in   1       Clock (afi_half_clk domain).
//  iRST_n             in   1       Reset: synchronous, active-low.
//  local_init_done    in   1       Controller calibration/initialisation complete.
//  m0_req, m1_req     in   1       Request, level; held until the port's done.
//  m0_we, m1_we       in   1       1 = write, 0 = read; valid while req.
//  m0_addr, m1_addr   in   32      Byte address; word address = addr[ADDR_W+1:2].
//  m0_wdata, m1_wdata in   DATA_W  Write data; valid while req.
//  m0_rdata, m1_rdata out  DATA_W  Read data; registered; holds until the next read on that port.
//  m0_done, m1_done   out  1       One-cycle completion pulse.
//  m0_err, m1_err     out  1       Qualifies done: 1 = read timed out.
//  avl_waitrequest_n  in   1       Controller ready (avl_ready).
//  avl_address        out  ADDR_W  Command word address.
//  avl_read           out  1       Read command.
//  avl_write          out  1       Write command.
//  avl_burstbegin     out  1       First cycle of each command.
//  avl_writedata      out  DATA_W  Write data.
//  avl_readdata       in   DATA_W  Read data.
//  avl_readdatavalid  in   1       Read data valid.
//  grant              out  1       Port owning the current or last transaction.
//  c_state            out  3       Current FSM state code (debug).
// BEHAVIOUR
//  Reset (iRST_n=0 at a posedge):
//   - All outputs 0; state INIT; last_grant=1, so port 0 wins the first tie.
//   - A transaction in flight is abandoned with no done pulse.
//   - avl_read/avl_write are low from the first cycle after the reset edge.
//  States:
//   INIT=0:   Wait for local_init_done=1, then go to IDLE.
//   IDLE=1:   No req: stay. local_init_done=0: go to INIT.
//             Otherwise pick the winner, latch we/addr/wdata into internal registers, set grant, go to CMD.
//   CMD=2:    avl_read=!we or avl_write=we, held with avl_address and avl_writedata stable.
//             avl_burstbegin=1 only on the first CMD cycle.
//             Command is accepted on the edge where avl_waitrequest_n=1.
//             Accepted write -> DONE. Accepted read -> RDWAIT, with the timeout counter cleared.
//             avl_read/avl_write drop in the cycle after acceptance.
//   RDWAIT=3: avl_readdatavalid=1 -> capture avl_readdata into the granted port's rdata, go to DONE, err=0.
//             Counter reaches TIMEOUT -> granted rdata=0, err=1, go to DONE.
//             Readdatavalid and timeout on the same edge: the data wins.
//   DONE=4:   Pulse the granted port's done (and err) for exactly one cycle; go to IDLE.
//             The port must drop req in the cycle after done, or IDLE treats it as a new request.
//  Arbitration in IDLE:
//   - Single requester wins.
//   - Both requesting: grant !last_grant. last_grant updates on each grant.
//   - No port is starved: at most one foreign transaction runs between its grants.
//  Latency, with zero-wait controller and readdata returned N cycles after acceptance:
//   - Write: req at edge k -> done high in cycle k+2.
//   - Read: req at edge k -> done high in cycle k+N+2.
//  Other rules:
//   - Stray avl_readdatavalid outside RDWAIT is ignored.
//   - Requests arriving during INIT wait.
//   - local_init_done falling mid-transaction: the transaction completes normally, then INIT.
//   - The non-granted port's outputs do not change during a transaction.
//   - Unused states 5-7 return to IDLE.
// TESTING
//  1. Reset, local_init_done=1, m0 write addr=0x10 data=0xCAFEF00D, ready=1
//     -> avl_address=4, avl_write and burstbegin for 1 cycle, m0_done 2 cycles after req.
//  2. m0 read addr=0x10, readdatavalid 5 cycles after acceptance with 0xCAFEF00D
//     -> m0_rdata=0xCAFEF00D, m0_done=1, m0_err=0, m1 outputs unchanged.
//  3. m0_req and m1_req both held high for 4 transactions -> grants 0,1,0,1.
//  4. avl_waitrequest_n=0 for 7 cycles during CMD
//     -> avl_read, avl_address and avl_writedata stable, burstbegin only in the first cycle.
//  5. Read with readdatavalid never asserted, TIMEOUT=15
//     -> m1_done with m1_err=1 and m1_rdata=0 after 15 RDWAIT cycles.
//  6. iRST_n=0 in RDWAIT, then a late readdatavalid arrives
//     -> no done pulse, state INIT, rdata stays 0.

Source files
------------

// File: rtl/lpddr2_port_arbiter.sv
// Two-port round-robin arbiter/sequencer for the LPDDR2 Avalon-MM local port.
// Port 0 is instruction fetch, port 1 is data; one word per req/done handshake.
module lpddr2_port_arbiter #(
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              local_init_done,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic              m1_err,
    input  logic              avl_waitrequest_n,
    output logic [ADDR_W-1:0] avl_address,
    output logic              avl_read,
    output logic              avl_write,
    output logic              avl_burstbegin,
    output logic [DATA_W-1:0] avl_writedata,
    input  logic [DATA_W-1:0] avl_readdata,
    input  logic              avl_readdatavalid,
    output logic              grant,
    output logic [2:0]        c_state
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_CMD    = 3'd2,
        S_RDWAIT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state_q;
    logic              last_grant_q, grant_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;
    logic              done0_q, done1_q, err0_q, err1_q;
    logic              rd_q, wr_q, bb_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              win_d, timeout_d;

    // Ties go to the port that did not win last time.
    always_comb begin
        win_d     = m1_req & (~m0_req | ~last_grant_q);
        cnt_d     = cnt_q + 1'b1;
        timeout_d = (cnt_d == CNT_W'(TIMEOUT));
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q      <= S_INIT;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            bb_q         <= 1'b0;
            cnt_q        <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            bb_q    <= 1'b0;
            case (state_q)
                S_INIT: if (local_init_done) state_q <= S_IDLE;
                S_IDLE: begin
                    if (!local_init_done) begin
                        state_q <= S_INIT;
                    end else if (m0_req || m1_req) begin
                        grant_q      <= win_d;
                        last_grant_q <= win_d;
                        we_q         <= win_d ? m1_we : m0_we;
                        addr_q       <= win_d ? m1_addr[ADDR_W+1:2] : m0_addr[ADDR_W+1:2];
                        wdata_q      <= win_d ? m1_wdata : m0_wdata;
                        rd_q         <= ~(win_d ? m1_we : m0_we);
                        wr_q         <= win_d ? m1_we : m0_we;
                        bb_q         <= 1'b1;
                        state_q      <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (avl_waitrequest_n) begin
                        rd_q  <= 1'b0;
                        wr_q  <= 1'b0;
                        cnt_q <= '0;
                        if (we_q) begin
                            done0_q <= ~grant_q;
                            done1_q <= grant_q;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RDWAIT;
                        end
                    end
                end
                S_RDWAIT: begin
                    cnt_q <= cnt_d;
                    // Data beats the timeout when both land on the same edge.
                    if (avl_readdatavalid || timeout_d) begin
                        if (grant_q) rdata1_q <= avl_readdatavalid ? avl_readdata : '0;
                        else         rdata0_q <= avl_readdatavalid ? avl_readdata : '0;
                        done0_q <= ~grant_q;
                        done1_q <= grant_q;
                        err0_q  <= ~grant_q & ~avl_readdatavalid;
                        err1_q  <= grant_q & ~avl_readdatavalid;
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m0_rdata       = rdata0_q;
    assign m1_rdata       = rdata1_q;
    assign m0_done        = done0_q;
    assign m1_done        = done1_q;
    assign m0_err         = err0_q;
    assign m1_err         = err1_q;
    assign avl_address    = addr_q;
    assign avl_writedata  = wdata_q;
    assign avl_read       = rd_q;
    assign avl_write      = wr_q;
    assign avl_burstbegin = bb_q;
    assign grant          = grant_q;
    assign c_state        = state_q;

    // Byte-lane and upper address bits are not part of the word address.
    logic unused_addr;
    assign unused_addr = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0], m1_addr[31:ADDR_W+2], m1_addr[1:0]};
endmodule

// File: tb/tb_lpddr2_port_arbiter.sv
// Directed bench for lpddr2_port_arbiter: writes, reads, arbitration, backpressure,
// timeout, data/timeout tie and reset in the middle of a read.
module tb_lpddr2_port_arbiter;
    logic        iCLK = 1'b0;
    logic        iRST_n, local_init_done;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic        m0_done, m0_err, m1_done, m1_err;
    logic        avl_waitrequest_n, avl_read, avl_write, avl_burstbegin, avl_readdatavalid;
    logic [26:0] avl_address;
    logic [31:0] avl_writedata, avl_readdata;
    logic        grant;
    logic [2:0]  c_state;

    int cmp  = 0;
    int errs = 0;

    always #5 iCLK = ~iCLK;

    lpddr2_port_arbiter #(.ADDR_W(27), .DATA_W(32), .TIMEOUT(15)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .local_init_done(local_init_done),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .avl_waitrequest_n(avl_waitrequest_n), .avl_address(avl_address),
        .avl_read(avl_read), .avl_write(avl_write), .avl_burstbegin(avl_burstbegin),
        .avl_writedata(avl_writedata), .avl_readdata(avl_readdata),
        .avl_readdatavalid(avl_readdatavalid), .grant(grant), .c_state(c_state)
    );

    task automatic step;
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iRST_n = 0; local_init_done = 0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        avl_waitrequest_n = 1; avl_readdata = 0; avl_readdatavalid = 0;
        step; step;
        chk("rst_state", 32'(c_state), 0);
        chk("rst_outs", {27'(avl_address), avl_read, avl_write, avl_burstbegin, grant, m0_done}, 0);
        chk("rst_rdata", m0_rdata | m1_rdata, 0);
        iRST_n = 1;
        step;
        chk("init_wait", 32'(c_state), 0);
        local_init_done = 1;
        step;
        chk("init_idle", 32'(c_state), 1);

        // 1: m0 write
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hCAFEF00D;
        step;
        chk("t1_state_cmd", 32'(c_state), 2);
        chk("t1_addr", 32'(avl_address), 4);
        chk("t1_wr_bb", {avl_write, avl_read, avl_burstbegin}, 3'b101);
        chk("t1_wdata", avl_writedata, 32'hCAFEF00D);
        chk("t1_nodone_yet", 32'(m0_done), 0);
        step;
        chk("t1_wr_drop", {avl_write, avl_burstbegin}, 2'b00);
        chk("t1_done", {m0_done, m0_err, m1_done}, 3'b100);
        chk("t1_state_done", 32'(c_state), 4);
        m0_req = 0;
        step;
        chk("t1_done_pulse", 32'(m0_done), 0);
        chk("t1_state_idle", 32'(c_state), 1);

        // 2: m0 read, data 5 cycles after acceptance
        m0_req = 1; m0_we = 0;
        step;
        chk("t2_rd", {avl_read, avl_write, grant}, 3'b100);
        step;
        chk("t2_rdwait", 32'(c_state), 3);
        chk("t2_rd_drop", 32'(avl_read), 0);
        for (int i = 0; i < 4; i++) begin
            step;
            chk("t2_wait_nodone", 32'(m0_done), 0);
        end
        avl_readdatavalid = 1; avl_readdata = 32'hCAFEF00D;
        step;
        chk("t2_rdata", m0_rdata, 32'hCAFEF00D);
        chk("t2_done", {m0_done, m0_err}, 2'b10);
        chk("t2_m1_untouched", {m1_rdata[30:0], m1_done}, 0);
        avl_readdatavalid = 0; m0_req = 0;
        step;
        chk("t2_hold", m0_rdata, 32'hCAFEF00D);

        // 3: both ports hold req from a fresh reset
        iRST_n = 0;
        step;
        chk("t3_rst_rdata", m0_rdata, 0);
        iRST_n = 1;
        step;
        m0_req = 1; m0_we = 1; m0_wdata = 32'h11111111;
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h22222222;
        for (int t = 0; t < 4; t++) begin
            step;
            chk("t3_grant", 32'(grant), 32'(t % 2));
            chk("t3_wdata", avl_writedata, (t % 2) ? 32'h22222222 : 32'h11111111);
            step;
            chk("t3_done", {m1_done, m0_done}, (t % 2) ? 2'b10 : 2'b01);
            step;
        end
        m0_req = 0; m1_req = 0;
        step;

        // 4: backpressure for 7 CMD cycles on an m1 read
        avl_waitrequest_n = 0;
        m1_req = 1; m1_we = 0; m1_addr = 32'h44; m1_wdata = 32'h12345678;
        step;
        chk("t4_first", {avl_read, avl_burstbegin}, 2'b11);
        chk("t4_addr0", 32'(avl_address), 32'h11);
        for (int i = 0; i < 6; i++) begin
            step;
            chk("t4_hold_cmd", {avl_read, avl_burstbegin, 29'(c_state)}, {2'b10, 29'd2});
            chk("t4_hold_addr", 32'(avl_address), 32'h11);
            chk("t4_hold_wdata", avl_writedata, 32'h12345678);
        end
        avl_waitrequest_n = 1;
        step;
        chk("t4_accept", {avl_read, 29'(c_state)}, {1'b0, 29'd3});
        avl_readdatavalid = 1; avl_readdata = 32'hA5A5A5A5;
        step;
        chk("t4_done", {m1_done, m1_err, m0_done}, 3'b100);
        chk("t4_rdata", m1_rdata, 32'hA5A5A5A5);
        chk("t4_m0_untouched", m0_rdata, 0);
        avl_readdatavalid = 0; m1_req = 0;
        step;

        // 5: m1 read timeout after 15 RDWAIT cycles
        m1_req = 1;
        step;
        step;
        for (int i = 0; i < 14; i++) begin
            step;
            chk("t5_waiting", {m1_done, 29'(c_state)}, {1'b0, 29'd3});
        end
        step;
        chk("t5_timeout", {m1_done, m1_err}, 2'b11);
        chk("t5_rdata_zero", m1_rdata, 0);
        m1_req = 0;
        step;
        chk("t5_err_pulse", {m1_done, m1_err}, 2'b00);

        // data and timeout on the same edge: data wins
        m1_req = 1;
        step;
        step;
        for (int i = 0; i < 14; i++) step;
        avl_readdatavalid = 1; avl_readdata = 32'h0BADF00D;
        step;
        chk("tie_done", {m1_done, m1_err}, 2'b10);
        chk("tie_rdata", m1_rdata, 32'h0BADF00D);
        avl_readdatavalid = 0; m1_req = 0;
        step;

        // 6: reset during RDWAIT, then a late readdatavalid
        m0_req = 1; m0_we = 0; m0_addr = 32'h80;
        step;
        step;
        step;
        chk("t6_rdwait", 32'(c_state), 3);
        iRST_n = 0;
        step;
        chk("t6_rst_state", 32'(c_state), 0);
        chk("t6_rst_outs", {avl_read, avl_write, grant, m0_done, m1_done}, 0);
        iRST_n = 1; local_init_done = 0; m0_req = 0;
        step;
        avl_readdatavalid = 1; avl_readdata = 32'hDEADBEEF;
        step;
        chk("t6_no_done", {m0_done, m0_err, m1_done}, 0);
        chk("t6_rdata", m0_rdata, 0);
        chk("t6_state", 32'(c_state), 0);
        avl_readdatavalid = 0;
        step;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
